// File: rtl/edge_fb_writer.sv
// Packs a strobe-qualified 4-bit edge pixel stream (optionally binarized) into
// 16-bit frame-buffer writes, tracking frame position and start-of-frame alignment.
module edge_fb_writer #(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        edge_data,
  input  logic              in_ready,
  input  logic              sof,
  input  logic              bin_en,
  input  logic [3:0]        thresh,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              frame_done,
  output logic              sync_err
);

  localparam int NWORDS = IMG_W * IMG_H / 4;
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(NWORDS - 1);

  localparam logic [0:0] S_WAIT_SOF = 1'b0;
  localparam logic [0:0] S_RUN      = 1'b1;

  // Handshake: a pixel is taken on any cycle with in_ready=1 that the FSM
  // permits; there is no backpressure and every wr_en must be absorbed.
  logic [0:0]        state_q, state_d;
  logic [1:0]        lane_q, lane_d;
  logic [ADDR_W-1:0] word_q, word_d;
  logic [11:0]       pack_q, pack_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]       wr_data_q, wr_data_d;
  logic              frame_done_q, frame_done_d;
  logic              sync_err_q, sync_err_d;
  logic [3:0]        pix;

  always_comb begin
    state_d      = state_q;
    lane_d       = lane_q;
    word_d       = word_q;
    pack_d       = pack_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_done_d = 1'b0;
    sync_err_d   = 1'b0;
    pix          = bin_en ? ((edge_data >= thresh) ? 4'hF : 4'h0) : edge_data;

    if (in_ready && sof) begin
      // Any sof restarts at pixel 0; it is an error only if a frame was partly received.
      sync_err_d  = (state_q == S_RUN) && ((lane_q != 2'd0) || (word_q != '0));
      state_d     = S_RUN;
      pack_d[3:0] = pix;
      lane_d      = 2'd1;
      word_d      = '0;
    end else if (in_ready && (state_q == S_RUN)) begin
      lane_d = lane_q + 2'd1;
      case (lane_q)
        2'd0: pack_d[3:0]  = pix;
        2'd1: pack_d[7:4]  = pix;
        2'd2: pack_d[11:8] = pix;
        default: begin
          wr_en_d   = 1'b1;
          wr_addr_d = word_q;
          wr_data_d = {pix, pack_q};
          if (word_q == LAST_WORD) begin
            word_d       = '0;
            frame_done_d = 1'b1;
            state_d      = S_WAIT_SOF;
          end else begin
            word_d = word_q + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_WAIT_SOF;
      lane_q       <= 2'd0;
      word_q       <= '0;
      pack_q       <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      word_q       <= word_d;
      pack_q       <= pack_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign frame_done = frame_done_q;
  assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_edge_fb_writer.sv
// Bench for edge_fb_writer on a tiny 8x2 frame: directed scenarios with literal
// expectations plus a randomized run checked each cycle against a pixel-index model.
module tb_edge_fb_writer;
  localparam int IMG_W  = 8;
  localparam int IMG_H  = 2;
  localparam int ADDR_W = 3;
  localparam int NPIX   = IMG_W * IMG_H;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [3:0]        edge_data = 4'h0;
  logic              in_ready = 1'b0;
  logic              sof = 1'b0;
  logic              bin_en = 1'b0;
  logic [3:0]        thresh = 4'h0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic              frame_done;
  logic              sync_err;

  int n_pass = 0;
  int n_total = 0;
  logic chk_en = 1'b0;

  edge_fb_writer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .edge_data(edge_data), .in_ready(in_ready), .sof(sof),
    .bin_en(bin_en), .thresh(thresh), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .frame_done(frame_done), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: frame position is a pixel index, word = idx/4, lane = idx%4.
  logic              m_wr_en = 1'b0, m_fd = 1'b0, m_se = 1'b0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [15:0]       m_data = '0;
  logic [3:0]        cur[4];
  bit                in_frame = 1'b0;
  int                pix_idx = 0;

  function automatic logic [3:0] xform(input logic [3:0] d, input logic b, input logic [3:0] t);
    if (!b) return d;
    return (d >= t) ? 4'hF : 4'h0;
  endfunction

  task automatic model_step();
    m_wr_en = 1'b0; m_fd = 1'b0; m_se = 1'b0;
    if (rst) begin
      m_addr = '0; m_data = '0; in_frame = 1'b0; pix_idx = 0;
    end else if (in_ready) begin
      if (sof) begin
        if (in_frame && pix_idx != 0) m_se = 1'b1;
        in_frame = 1'b1;
        pix_idx  = 0;
      end
      if (in_frame) begin
        cur[pix_idx % 4] = xform(edge_data, bin_en, thresh);
        if (pix_idx % 4 == 3) begin
          m_wr_en = 1'b1;
          m_addr  = ADDR_W'(pix_idx / 4);
          m_data  = {cur[3], cur[2], cur[1], cur[0]};
        end
        pix_idx++;
        if (pix_idx == NPIX) begin
          pix_idx = 0; in_frame = 1'b0; m_fd = 1'b1;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en)
      check("cycle{wr_en,fd,se,addr,data}",
            32'({wr_en, frame_done, sync_err, wr_addr, wr_data}),
            32'({m_wr_en, m_fd, m_se, m_addr, m_data}));
  end

  task automatic tick(input logic r, input logic ir, input logic s, input logic [3:0] d);
    @(negedge clk);
    rst = r; in_ready = ir; sof = s; edge_data = d;
  endtask

  task automatic do_reset();
    tick(1'b1, 1'b0, 1'b0, 4'h0);
    tick(1'b1, 1'b0, 1'b0, 4'h0);
  endtask

  task automatic check_outs(input string name, input logic we, input logic [ADDR_W-1:0] a,
                            input logic [15:0] dt, input logic fd, input logic se);
    check(name, 32'({wr_en, wr_addr, wr_data, frame_done, sync_err}), 32'({we, a, dt, fd, se}));
  endtask

  initial begin
    do_reset();
    chk_en = 1'b1;
    tick(1'b0, 1'b0, 1'b0, 4'h0);
    check_outs("reset_outputs", 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);

    // Pass-through packing order.
    bin_en = 1'b0;
    tick(1'b0, 1'b1, 1'b1, 4'h1);
    tick(1'b0, 1'b1, 1'b0, 4'h2);
    tick(1'b0, 1'b1, 1'b0, 4'h3);
    tick(1'b0, 1'b1, 1'b0, 4'h4);
    tick(1'b0, 1'b0, 1'b0, 4'h0);
    check_outs("pack_4321", 1'b1, 3'd0, 16'h4321, 1'b0, 1'b0);
    check("model_pin_4321", 32'(m_data), 32'h4321);

    // Binarized, back-to-back then with gaps.
    for (int g = 0; g < 2; g++) begin
      do_reset();
      bin_en = 1'b1; thresh = 4'h8;
      tick(1'b0, 1'b1, 1'b1, 4'h7);
      if (g == 1) tick(1'b0, 1'b0, 1'b0, 4'h9);
      tick(1'b0, 1'b1, 1'b0, 4'h8);
      if (g == 1) tick(1'b0, 1'b0, 1'b0, 4'h9);
      tick(1'b0, 1'b1, 1'b0, 4'hF);
      if (g == 1) tick(1'b0, 1'b0, 1'b0, 4'h9);
      tick(1'b0, 1'b1, 1'b0, 4'h0);
      tick(1'b0, 1'b0, 1'b0, 4'h0);
      check_outs(g == 0 ? "bin_0ff0" : "bin_0ff0_gaps", 1'b1, 3'd0, 16'h0FF0, 1'b0, 1'b0);
    end
    check("model_pin_0ff0", 32'(m_data), 32'h0FF0);

    // Full 16-pixel frame, then stray pixels, then a new frame.
    do_reset();
    bin_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick(1'b0, 1'b1, i == 0, 4'(i));
      if (i >= 4 && i % 4 == 0)
        check_outs("frame_word", 1'b1, 3'(i / 4 - 1),
                   {4'(i - 1), 4'(i - 2), 4'(i - 3), 4'(i - 4)}, 1'b0, 1'b0);
      else if (i > 0)
        check("frame_gap_no_wr", 32'(wr_en), 32'd0);
    end
    tick(1'b0, 1'b1, 1'b0, 4'h5);
    check_outs("frame_last_word", 1'b1, 3'd3, 16'hFEDC, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b1, 1'b0, 4'h5);
      check("no_sof_no_wr", 32'({wr_en, frame_done}), 32'd0);
    end
    tick(1'b0, 1'b1, 1'b1, 4'hA);
    tick(1'b0, 1'b1, 1'b0, 4'hB);
    tick(1'b0, 1'b1, 1'b0, 4'hC);
    tick(1'b0, 1'b1, 1'b0, 4'hD);
    tick(1'b0, 1'b0, 1'b0, 4'h0);
    check_outs("new_frame_addr0", 1'b1, 3'd0, 16'hDCBA, 1'b0, 1'b0);

    // Mid-frame sof after 6 pixels.
    do_reset();
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, i == 0, 4'(i + 1));
    tick(1'b0, 1'b1, 1'b1, 4'h9);
    tick(1'b0, 1'b0, 1'b0, 4'h0);
    check_outs("sync_err_pulse", 1'b0, 3'd0, 16'h4321, 1'b0, 1'b1);
    tick(1'b0, 1'b1, 1'b0, 4'h8);
    check("sync_err_one_cycle", 32'(sync_err), 32'd0);
    tick(1'b0, 1'b1, 1'b0, 4'h7);
    tick(1'b0, 1'b1, 1'b0, 4'h6);
    tick(1'b0, 1'b0, 1'b0, 4'h0);
    check_outs("resync_word", 1'b1, 3'd0, 16'h6789, 1'b0, 1'b0);

    // No sof after reset: nothing is written.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b1, 1'b0, 4'(i + 3));
      check("no_sof_after_reset", 32'(wr_en), 32'd0);
    end

    // Reset in the middle of a word.
    do_reset();
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, i == 0, 4'(i + 10));
    tick(1'b1, 1'b1, 1'b0, 4'h1);
    tick(1'b0, 1'b0, 1'b0, 4'h0);
    check_outs("rst_mid_word", 1'b0, 3'd0, 16'h0000, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 4'h3);
    tick(1'b0, 1'b1, 1'b0, 4'h4);
    check("rst_no_stray_wr", 32'(wr_en), 32'd0);
    tick(1'b0, 1'b0, 1'b0, 4'h0);
    check("rst_no_stray_wr2", 32'(wr_en), 32'd0);
    tick(1'b0, 1'b1, 1'b1, 4'h2);
    tick(1'b0, 1'b1, 1'b0, 4'h4);
    tick(1'b0, 1'b1, 1'b0, 4'h6);
    tick(1'b0, 1'b1, 1'b0, 4'h8);
    tick(1'b0, 1'b0, 1'b0, 4'h0);
    check_outs("rst_then_frame", 1'b1, 3'd0, 16'h8642, 1'b0, 1'b0);

    // Randomized traffic checked by the per-cycle compare process.
    for (int i = 0; i < 4000; i++) begin
      tick($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 24) == 0, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 15) == 0) begin
        bin_en = 1'($urandom_range(0, 1));
        thresh = 4'($urandom_range(0, 15));
      end
    end
    tick(1'b0, 1'b0, 1'b0, 4'h0);
    tick(1'b0, 1'b0, 1'b0, 4'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
